// File: rtl/serial_mag_cmp_pkg.sv
// serial_mag_cmp_pkg: shared encodings for the serial magnitude comparator.
// FSM states, verdict encoding and the slice-index width helper.
package serial_mag_cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      EQ = 2'd0,
      LT = 2'd1,
      GT = 2'd2
   } cmp_res_t;

   // Slice index needs at least one bit even for a single slice.
   function automatic int idx_width(input int s);
      return (s <= 2) ? 1 : $clog2(s);
   endfunction

endpackage

// File: rtl/serial_mag_cmp_slice.sv
// cmp2_slice: combinational 2-bit unsigned magnitude comparator.
// Exactly one of eq/lt/gt is high for any input pair.
module cmp2_slice (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       eq,
   output logic       lt,
   output logic       gt
);

   always_comb begin
      eq = (x == y);
      lt = (x < y);
      gt = (x > y);
   end

endmodule

// File: rtl/serial_mag_cmp.sv
// serial_mag_cmp: W-bit unsigned compare using one shared 2-bit slice,
// MSB pair first, stopping at the first unequal pair.
module serial_mag_cmp
   import serial_mag_cmp_pkg::*;
#(
   parameter  int W  = 8,
   localparam int S  = W / 2,
   localparam int IW = idx_width(S)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          busy,
   output logic          done,
   output logic          a_eq,
   output logic          a_lt,
   output logic          a_gt,
   output logic [IW:0]   slices_used
);

   generate
      if ((W % 2) != 0 || W < 2) begin : g_bad_w
         $error("serial_mag_cmp: W must be even and >= 2");
      end
   endgenerate

   localparam logic [IW-1:0] IDX_TOP = IW'(S - 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);
   localparam logic [IW:0]   CNT_ONE = (IW + 1)'(1);

   state_t          state;
   logic [W-1:0]    ra;
   logic [W-1:0]    rb;
   logic [IW-1:0]   idx;
   logic [1:0]      sx;
   logic [1:0]      sy;
   logic            s_eq;
   logic            s_lt;
   logic            s_gt;

   // Only the latched operands ever reach the slice.
   always_comb begin
      sx = ra[{idx, 1'b0} +: 2];
      sy = rb[{idx, 1'b0} +: 2];
   end

   cmp2_slice u_slice (
      .x  (sx),
      .y  (sy),
      .eq (s_eq),
      .lt (s_lt),
      .gt (s_gt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         ra          <= '0;
         rb          <= '0;
         idx         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         a_eq        <= 1'b0;
         a_lt        <= 1'b0;
         a_gt        <= 1'b0;
         slices_used <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  ra          <= a;
                  rb          <= b;
                  idx         <= IDX_TOP;
                  a_eq        <= 1'b0;
                  a_lt        <= 1'b0;
                  a_gt        <= 1'b0;
                  slices_used <= '0;
                  busy        <= 1'b1;
                  state       <= ST_RUN;
               end
            end
            ST_RUN: begin
               slices_used <= slices_used + CNT_ONE;
               if (s_lt || s_gt) begin
                  a_lt  <= s_lt;
                  a_gt  <= s_gt;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else if (idx == '0) begin
                  a_eq  <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx <= idx - IDX_ONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb_serial_mag_cmp: directed and random checks of serial_mag_cmp (W=8)
// against a timeline model of the compare.
module tb_serial_mag_cmp;
   import serial_mag_cmp_pkg::*;

   localparam int W = 8;
   localparam int S = W / 2;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         a_eq;
   logic         a_lt;
   logic         a_gt;
   logic [2:0]   slices_used;

   int n_cmp = 0;
   int n_bad = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   serial_mag_cmp #(.W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .a_eq        (a_eq),
      .a_lt        (a_lt),
      .a_gt        (a_gt),
      .slices_used (slices_used)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   function automatic int slices_for(input logic [W-1:0] x,
                                     input logic [W-1:0] y);
      logic [W-1:0] d;
      d = x ^ y;
      if (d == '0) return S;
      for (int i = W - 1; i >= 0; i--)
         if (d[i]) return S - i / 2;
      return S;
   endfunction

   function automatic cmp_res_t ref_res(input logic [W-1:0] x,
                                        input logic [W-1:0] y);
      if (x == y) return EQ;
      if (x < y) return LT;
      return GT;
   endfunction

   // Timeline model: an accepted compare stays busy for s cycles,
   // then shows done for one cycle, then returns to idle.
   logic     m_busy, m_done, m_eq, m_lt, m_gt;
   int       m_used, m_left;
   cmp_res_t p_res;

   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_eq   <= 1'b0;
         m_lt   <= 1'b0;
         m_gt   <= 1'b0;
         m_used <= 0;
         m_left <= 0;
      end else if (m_left > 0) begin
         m_used <= m_used + 1;
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_eq   <= (p_res == EQ);
            m_lt   <= (p_res == LT);
            m_gt   <= (p_res == GT);
         end
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (start) begin
         p_res  <= ref_res(a, b);
         m_left <= slices_for(a, b);
         m_busy <= 1'b1;
         m_eq   <= 1'b0;
         m_lt   <= 1'b0;
         m_gt   <= 1'b0;
         m_used <= 0;
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("flags", 32'({a_eq, a_lt, a_gt}), 32'({m_eq, m_lt, m_gt}));
         chk("slices_used", 32'(slices_used), m_used);
         chk("onehot0", 32'($countones({a_eq, a_lt, a_gt}) <= 1), 32'd1);
      end
   end

   task automatic kick(input logic [W-1:0] ta, input logic [W-1:0] tb);
      @(negedge clk);
      a = ta;
      b = tb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the negedge after edge n0; returns edge count when done seen.
   task automatic wait_done(input int n0, output int n, output int nbusy);
      bit seen;
      seen = 1'b0;
      n = n0;
      nbusy = 0;
      while (!seen && n < 30) begin
         if (done) seen = 1'b1;
         else begin
            if (busy) nbusy++;
            @(negedge clk);
            n++;
         end
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_res(input string nm, input int lat, input int exp_lat,
                             input logic [2:0] fl, input int used);
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_flags"}, 32'({a_eq, a_lt, a_gt}), 32'(fl));
      chk({nm, "_used"}, 32'(slices_used), used);
   endtask

   initial begin
      int n, nb;
      reset = 1'b1;
      start = 1'b1;
      a = 8'h5A;
      b = 8'h11;
      repeat (3) @(negedge clk);
      checking = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("reset_idle", 32'({busy, done, a_eq, a_lt, a_gt, slices_used}),
             32'd0);
      end

      kick(8'hA5, 8'hA5);
      wait_done(1, n, nb);
      chk("eq_busy_cycles", nb, 4);
      expect_res("eq", n, 5, 3'b100, 4);

      kick(8'h80, 8'h7F);
      wait_done(1, n, nb);
      chk("msb_busy_cycles", nb, 1);
      expect_res("msb_gt", n, 2, 3'b001, 1);

      kick(8'h3C, 8'h3D);
      a = 8'hFF;
      wait_done(1, n, nb);
      expect_res("lsb_lt", n, 5, 3'b010, 4);

      kick(8'h10, 8'h20);
      start = 1'b1;
      a = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      wait_done(2, n, nb);
      expect_res("ignored_start", n, 3, 3'b010, 2);
      kick(8'h01, 8'h00);
      wait_done(1, n, nb);
      expect_res("back_to_back", n, 5, 3'b001, 4);

      kick(8'h00, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_state", 32'({busy, done, a_eq, a_lt, a_gt, slices_used}),
          32'd0);
      repeat (6) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
      end
      kick(8'h02, 8'h01);
      wait_done(1, n, nb);
      expect_res("after_abort", n, 5, 3'b001, 4);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         a = W'($urandom);
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ (8'h01 << $urandom_range(0, 7));
            default: b = W'($urandom);
         endcase
         reset = ($urandom_range(0, 299) == 0);
      end
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
